// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access / writeback pipeline stage (IDLE -> MEM -> WB handshake FSM)
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   valid_i / ready_o           upstream handshake, op accepted when both are high
//   alu_result_i, store_data_i  ALU result or effective address, store data
//   is_load_i, is_store_i       memory op flags (both set executes as a load)
//   regwrite_i, rd_i            register write enable and destination
//   size_i, unsigned_i          access size (00 byte, 01 half, 1x word), zero-extend loads
//   mem_*                       single outstanding request held until mem_ack_i
//   regwrite_o, wa_o, wd_o      register-file write port
//   misalign_o                  one-cycle pulse after accepting a misaligned access
// Optional feature: define SUBWORD_LOAD_EN for byte/half accesses; otherwise every
// access is word-sized and size_i/unsigned_i are ignored.
module mem_wb_stage #(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [WIDTH-1:0]   alu_result_i,
    input  logic [WIDTH-1:0]   store_data_i,
    input  logic               is_load_i,
    input  logic               is_store_i,
    input  logic               regwrite_i,
    input  logic [REGBITS-1:0] rd_i,
    input  logic [1:0]         size_i,
    input  logic               unsigned_i,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [WIDTH-1:0]   mem_addr_o,
    output logic [WIDTH-1:0]   mem_wdata_o,
    output logic [3:0]         mem_be_o,
    input  logic               mem_ack_i,
    input  logic [WIDTH-1:0]   mem_rdata_i,
    output logic               regwrite_o,
    output logic [REGBITS-1:0] wa_o,
    output logic [WIDTH-1:0]   wd_o,
    output logic               misalign_o
);
    typedef enum logic [1:0] {IDLE, MEM, WB} state_t;
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   addr_q, addr_d, sdata_q, sdata_d, wd_q, wd_d, ld_data;
    logic [REGBITS-1:0] rd_q, rd_d;
    logic [1:0]         size_q, size_d, size_in;
    logic               load_q, load_d, uns_q, uns_d, rw_q, rw_d, mis_q, mis_d;
    logic               uns_in, accept, is_mem_in, mis_in;
    logic [7:0]         lane_b;
    logic [15:0]        lane_h;

`ifdef SUBWORD_LOAD_EN
    assign size_in = size_i;
    assign uns_in  = unsigned_i;
`else
    logic unused_cfg;
    assign unused_cfg = ^{size_i, unsigned_i};
    assign size_in    = 2'b10;
    assign uns_in     = 1'b0;
`endif

    assign accept    = valid_i && ready_o;
    assign is_mem_in = is_load_i || is_store_i;
    // size 11 is treated as word, so size[1] alone selects word alignment rules
    assign mis_in    = is_mem_in && (size_in[1] ? |alu_result_i[1:0] : size_in[0] & alu_result_i[0]);

    assign lane_b  = 8'(mem_rdata_i >> {addr_q[1:0], 3'b000});
    assign lane_h  = 16'(mem_rdata_i >> {addr_q[1], 4'b0000});
    assign ld_data = size_q[1] ? mem_rdata_i :
                     size_q[0] ? {{(WIDTH-16){~uns_q & lane_h[15]}}, lane_h} :
                                 {{(WIDTH-8){~uns_q & lane_b[7]}}, lane_b};

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // accept is only possible in IDLE/WB; acks outside MEM fall through to IDLE
    always_comb begin
        state_d = accept ? (!is_mem_in ? WB : mis_in ? IDLE : MEM) :
                  state_q == MEM ? (mem_ack_i ? (load_q ? WB : IDLE) : MEM) : IDLE;
    end

    always_comb begin
        ready_o     = state_q != MEM;
        mem_req_o   = state_q == MEM;
        mem_we_o    = mem_req_o && !load_q;
        mem_addr_o  = mem_req_o ? {addr_q[WIDTH-1:2], 2'b00} : '0;
        mem_be_o    = !mem_req_o ? 4'b0000 : size_q[1] ? 4'b1111 :
                      size_q[0] ? 4'b0011 << {addr_q[1], 1'b0} : 4'b0001 << addr_q[1:0];
        mem_wdata_o = !mem_we_o ? '0 : size_q[1] ? sdata_q :
                      size_q[0] ? {(WIDTH/16){sdata_q[15:0]}} : {(WIDTH/8){sdata_q[7:0]}};
        regwrite_o  = state_q == WB && rw_q && rd_q != '0;
        wa_o        = rd_q;
        wd_o        = wd_q;
        misalign_o  = mis_q;
    end

    always_comb begin
        addr_d  = addr_q;
        sdata_d = sdata_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        size_d  = size_q;
        load_d  = load_q;
        uns_d   = uns_q;
        rw_d    = rw_q;
        mis_d   = accept && mis_in;
        if (accept) begin
            addr_d  = alu_result_i;
            sdata_d = store_data_i;
            wd_d    = alu_result_i;
            rd_d    = rd_i;
            size_d  = size_in;
            load_d  = is_load_i;
            uns_d   = uns_in;
            rw_d    = regwrite_i;
        end else if (state_q == MEM && mem_ack_i && load_q) begin
            wd_d = ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            sdata_q <= '0;
            wd_q    <= '0;
            rd_q    <= '0;
            size_q  <= '0;
            load_q  <= 1'b0;
            uns_q   <= 1'b0;
            rw_q    <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            size_q  <= size_d;
            load_q  <= load_d;
            uns_q   <= uns_d;
            rw_q    <= rw_d;
            mis_q   <= mis_d;
        end
    end
endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameters SHALL be: WIDTH, 32, datapath width; REGBITS, 3, register-address width.
REQ-002 clk  in  1  clock; all state SHALL update on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 valid_i  in  1  upstream instruction valid; ready_o  out  1  stage can accept.
REQ-005 alu_result_i  in  WIDTH  ALU result or effective address; store_data_i  in  WIDTH  store data.
REQ-006 is_load_i, is_store_i, regwrite_i  in  1 each  op flags; rd_i  in  REGBITS  destination register.
REQ-007 size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word; unsigned_i  in  1  zero-extend loads.
REQ-008 mem_req_o, mem_we_o  out  1; mem_addr_o, mem_wdata_o  out  WIDTH; mem_be_o  out  4 byte enables.
REQ-009 mem_ack_i  in  1; mem_rdata_i  in  WIDTH  read data, valid with mem_ack_i.
REQ-010 regwrite_o  out  1; wa_o  out  REGBITS; wd_o  out  WIDTH  register-file write port.
REQ-011 misalign_o  out  1  one-cycle pulse on a misaligned access.

Function
REQ-012 FSM states SHALL be IDLE, MEM, WB; ready_o SHALL be 1 in IDLE and WB, 0 in MEM.
REQ-013 Accept = valid_i && ready_o; on accept all inputs SHALL be latched.
REQ-014 Accepted op with is_load_i or is_store_i SHALL go to MEM; otherwise to WB with wd = alu_result_i.
REQ-015 is_load_i && is_store_i SHALL be executed as a load.
REQ-016 In MEM, mem_req_o SHALL stay 1 with stable addr/we/be/wdata until the cycle mem_ack_i = 1.
REQ-017 mem_ack_i outside MEM SHALL be ignored.
REQ-018 On ack: load captures the aligned/extended mem_rdata_i and goes to WB; store goes to IDLE with no register write.
REQ-019 mem_addr_o SHALL be {alu_result[WIDTH-1:2], 2'b00}.
REQ-020 mem_be_o SHALL be 0001<<addr[1:0] (byte), 0011<<(2*addr[1]) (half), 1111 (word); mem_wdata_o SHALL replicate the byte/half across all lanes.
REQ-021 Load extraction SHALL select the lane(s) by addr[1:0] and sign-extend unless unsigned_i.
REQ-022 Misaligned (half with addr[0]=1; word with addr[1:0]!=0) SHALL raise no mem_req_o, pulse misalign_o in the cycle after accept, write nothing, and return to IDLE.
REQ-023 In WB, regwrite_o SHALL be 1 for exactly one cycle iff latched regwrite && rd != 0; wa_o/wd_o valid in that cycle.
REQ-024 WB with a same-cycle accept SHALL perform the writeback and latch the new op (back-to-back ALU ops, one per cycle).
REQ-025 Latency: ALU op accepted in cycle N writes in N+1; load acked in cycle M writes in M+1.

Reset
REQ-026 rst SHALL force IDLE; outputs: ready_o=1 (after reset cycle), mem_req_o=0, mem_we_o=0, mem_be_o=0, regwrite_o=0, misalign_o=0, wa_o=0, wd_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-027 rst during MEM SHALL drop mem_req_o at the next edge, discard the op, and not write back; a later ack SHALL be ignored.
REQ-028 rst SHALL take priority over accept and ack in the same cycle.

Configuration
REQ-029 Macro SUBWORD_LOAD_EN defined: byte/half accesses per REQ-020/021/022.
REQ-030 SUBWORD_LOAD_EN undefined: size_i and unsigned_i ignored, every access word-sized, mem_be_o=1111, misaligned iff addr[1:0]!=0.

Verification
REQ-031 ALU op alu_result=0x12345678, rd=3, regwrite=1 accepted cycle N -> regwrite_o=1, wa_o=3, wd_o=0x12345678 in N+1 only.
REQ-032 Signed byte load addr=0x103, ack after 3 wait cycles with rdata=0x80FF7F01 -> mem_be_o=1000 held 4 cycles, wd_o=0xFFFFFF80 one cycle after ack.
REQ-033 Half store addr=0x22, data=0x0000BEEF, immediate ack -> mem_we_o=1, mem_be_o=1100, mem_wdata_o=0xBEEFBEEF, no regwrite_o.
REQ-034 Word load addr=0x41 -> misalign_o pulse, mem_req_o never 1, no regwrite_o, ready_o=1 next cycle.
REQ-035 Load rd=0 with ack -> regwrite_o stays 0; ALU op rd=5 back-to-back after WB -> written the next cycle.
REQ-036 rst asserted during MEM wait, ack arrives 2 cycles later -> mem_req_o=0 after reset edge, no regwrite_o.
